// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the ball descriptor and register-map helpers
// for the sprite engine.
package vga_pkg;

  localparam int HACTIVE      = 1280;
  localparam int HFRONT_PORCH = 32;
  localparam int HSYNC        = 192;
  localparam int HBACK_PORCH  = 96;
  localparam int VACTIVE      = 480;
  localparam int VFRONT_PORCH = 10;
  localparam int VSYNC        = 2;
  localparam int VBACK_PORCH  = 33;

  // Widest radius the ATTR layout can carry (bits 30:24).
  localparam int RAD_MAX = 7;

  localparam logic [23:0] BG_RESET = 24'h000080;

  typedef struct packed {
    logic               enable;
    logic [RAD_MAX-1:0] radius;
    logic [23:0]        rgb;
    logic [9:0]         pos_v;
    logic [9:0]         pos_h;
  } ball_t;

  typedef enum logic {
    CM_IDLE    = 1'b0,
    CM_PENDING = 1'b1
  } commit_state_t;

  function automatic int pos_addr(input int i);
    return 2 * i;
  endfunction

  function automatic int attr_addr(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int bg_addr(input int n);
    return 2 * n;
  endfunction

  function automatic int ctrl_addr(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/ball_hit_unit.sv
// Combinational inside-circle test of one pixel against one ball.
module ball_hit_unit
  import vga_pkg::*;
#(
  parameter int RAD_W = 6
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  ball_t      i_ball,
  output logic       o_hit
);

  logic [9:0]         w_dx;
  logic [9:0]         w_dy;
  logic [19:0]        w_dx2;
  logic [19:0]        w_dy2;
  logic [20:0]        w_sum;
  logic [RAD_W-1:0]   w_rad;
  logic [2*RAD_W-1:0] w_r2;
  logic               w_unused;

  assign w_dx  = (i_x >= i_ball.pos_h) ? (i_x - i_ball.pos_h) : (i_ball.pos_h - i_x);
  assign w_dy  = (i_y >= i_ball.pos_v) ? (i_y - i_ball.pos_v) : (i_ball.pos_v - i_y);
  assign w_dx2 = 20'(w_dx) * 20'(w_dx);
  assign w_dy2 = 20'(w_dy) * 20'(w_dy);
  assign w_sum = 21'(w_dx2) + 21'(w_dy2);
  assign w_rad = i_ball.radius[RAD_W-1:0];
  assign w_r2  = (2*RAD_W)'(w_rad) * (2*RAD_W)'(w_rad);

  // Strict compare: the rim pixel at exactly r is outside, and r=0 never hits.
  assign o_hit = i_ball.enable && (w_sum < 21'(w_r2));

  assign w_unused = &{1'b0, i_ball.rgb, i_ball.radius};

endmodule

// File: rtl/vga_counters.sv
// Raster counters at two clocks per pixel; decodes sync, blank and the pixel clock.
module vga_counters #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 32,
  parameter int H_SYNC   = 192,
  parameter int H_BACK   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] o_hcount,
  output logic [9:0]  o_vcount,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_blank_n,
  output logic        o_vga_clk
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_hcount == 11'(H_TOTAL - 1)) begin
      r_hcount <= '0;
      if (r_vcount == 10'(V_TOTAL - 1)) r_vcount <= '0;
      else                              r_vcount <= r_vcount + 10'd1;
    end else begin
      r_hcount <= r_hcount + 11'd1;
    end
  end

  assign o_hcount  = r_hcount;
  assign o_vcount  = r_vcount;
  assign o_hs      = !((r_hcount >= 11'(H_ACTIVE + H_FRONT)) &&
                       (r_hcount <  11'(H_ACTIVE + H_FRONT + H_SYNC)));
  assign o_vs      = !((r_vcount >= 10'(V_ACTIVE + V_FRONT)) &&
                       (r_vcount <  10'(V_ACTIVE + V_FRONT + V_SYNC)));
  assign o_blank_n = (r_hcount < 11'(H_ACTIVE)) && (r_vcount < 10'(V_ACTIVE));
  assign o_vga_clk = r_hcount[0];

endmodule

// File: rtl/vga_sprite_engine.sv
// N_BALLS filled circles over a background colour, Avalon-MM programmable,
// with staged registers committed at the start of vertical blank.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int N_BALLS  = 4,
  parameter int RAD_W    = 6,
  parameter int ADDR_W   = 4,
  // Raster geometry is overridable so reduced rasters can be built.
  parameter int H_ACTIVE = HACTIVE,
  parameter int H_FRONT  = HFRONT_PORCH,
  parameter int H_SYNC   = HSYNC,
  parameter int H_BACK   = HBACK_PORCH,
  parameter int V_ACTIVE = VACTIVE,
  parameter int V_FRONT  = VFRONT_PORCH,
  parameter int V_SYNC   = VSYNC,
  parameter int V_BACK   = VBACK_PORCH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);

  // state      | meaning
  // CM_IDLE    | active bank matches the last commit; nothing waiting
  // CM_PENDING | commit requested; staging copied at the next boundary

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  logic [10:0]        w_hcount;
  logic [9:0]         w_vcount;
  logic               w_hs, w_vs, w_blank_n, w_vga_clk;
  logic               w_boundary;
  logic               w_wr, w_ctrl_commit;
  logic [31:0]        w_rd_data;
  logic [N_BALLS-1:0] w_hit;
  logic [23:0]        w_pix;
  logic               w_unused;

  ball_t              r_stg [N_BALLS];
  ball_t              r_act [N_BALLS];
  logic [23:0]        r_stg_bg, r_act_bg;
  commit_state_t      r_cm_state;
  logic [15:0]        r_frame_count;
  logic [31:0]        r_readdata;

  logic [N_BALLS-1:0] r_s1_hit;
  logic [23:0]        r_s1_rgb [N_BALLS];
  logic [23:0]        r_s1_bg;
  logic               r_s1_hs, r_s1_vs, r_s1_blank_n, r_s1_vga_clk;
  logic [23:0]        r_s2_rgb;
  logic               r_s2_hs, r_s2_vs, r_s2_blank_n, r_s2_vga_clk;

  vga_counters #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
  ) u_counters (
    .clk       (clk),
    .reset     (reset),
    .o_hcount  (w_hcount),
    .o_vcount  (w_vcount),
    .o_hs      (w_hs),
    .o_vs      (w_vs),
    .o_blank_n (w_blank_n),
    .o_vga_clk (w_vga_clk)
  );

  assign w_boundary    = (w_hcount == 11'(H_TOTAL - 1)) && (w_vcount == 10'(V_ACTIVE - 1));
  assign w_wr          = chipselect && write;
  assign w_ctrl_commit = w_wr && (address == ADDR_W'(ctrl_addr(N_BALLS))) && writedata[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BALLS; i++) r_stg[i] <= '0;
      r_stg_bg <= BG_RESET;
    end else if (w_wr) begin
      for (int i = 0; i < N_BALLS; i++) begin
        if (address == ADDR_W'(pos_addr(i))) begin
          r_stg[i].pos_v <= writedata[25:16];
          r_stg[i].pos_h <= writedata[9:0];
        end
        if (address == ADDR_W'(attr_addr(i))) begin
          r_stg[i].enable <= writedata[31];
          r_stg[i].radius <= RAD_MAX'(writedata[24 +: RAD_W]);
          r_stg[i].rgb    <= writedata[23:0];
        end
      end
      if (address == ADDR_W'(bg_addr(N_BALLS))) r_stg_bg <= writedata[23:0];
    end
  end

  // Copy samples staging before any same-cycle write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BALLS; i++) r_act[i] <= '0;
      r_act_bg <= BG_RESET;
    end else if (w_boundary && (r_cm_state == CM_PENDING)) begin
      for (int i = 0; i < N_BALLS; i++) r_act[i] <= r_stg[i];
      r_act_bg <= r_stg_bg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cm_state    <= CM_IDLE;
      r_frame_count <= '0;
    end else begin
      if (w_boundary) r_frame_count <= r_frame_count + 16'd1;
      case (r_cm_state)
        CM_IDLE:    if (w_ctrl_commit) r_cm_state <= CM_PENDING;
        CM_PENDING: if (w_boundary && !w_ctrl_commit) r_cm_state <= CM_IDLE;
        default:    r_cm_state <= CM_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (address == ADDR_W'(pos_addr(i))) begin
        w_rd_data[25:16] = r_stg[i].pos_v;
        w_rd_data[9:0]   = r_stg[i].pos_h;
      end
      if (address == ADDR_W'(attr_addr(i))) begin
        w_rd_data[31]         = r_stg[i].enable;
        w_rd_data[24 +: RAD_W] = r_stg[i].radius[RAD_W-1:0];
        w_rd_data[23:0]       = r_stg[i].rgb;
      end
    end
    if (address == ADDR_W'(bg_addr(N_BALLS)))   w_rd_data[23:0] = r_stg_bg;
    if (address == ADDR_W'(ctrl_addr(N_BALLS))) w_rd_data = {(r_cm_state == CM_PENDING), 15'd0, r_frame_count};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_readdata <= '0;
    else if (chipselect && read) r_readdata <= w_rd_data;
  end

  for (genvar g = 0; g < N_BALLS; g++) begin : g_hit
    ball_hit_unit #(.RAD_W(RAD_W)) u_hit (
      .i_x    (w_hcount[10:1]),
      .i_y    (w_vcount),
      .i_ball (r_act[g]),
      .o_hit  (w_hit[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_hit     <= '0;
      for (int i = 0; i < N_BALLS; i++) r_s1_rgb[i] <= '0;
      r_s1_bg      <= '0;
      r_s1_hs      <= 1'b1;
      r_s1_vs      <= 1'b1;
      r_s1_blank_n <= 1'b0;
      r_s1_vga_clk <= 1'b0;
    end else begin
      r_s1_hit     <= w_hit;
      for (int i = 0; i < N_BALLS; i++) r_s1_rgb[i] <= r_act[i].rgb;
      r_s1_bg      <= r_act_bg;
      r_s1_hs      <= w_hs;
      r_s1_vs      <= w_vs;
      r_s1_blank_n <= w_blank_n;
      r_s1_vga_clk <= w_vga_clk;
    end
  end

  // Walk downward so the lowest-index hitting ball has the last word.
  always_comb begin
    w_pix = r_s1_bg;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) w_pix = r_s1_rgb[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_rgb     <= '0;
      r_s2_hs      <= 1'b1;
      r_s2_vs      <= 1'b1;
      r_s2_blank_n <= 1'b0;
      r_s2_vga_clk <= 1'b0;
    end else begin
      r_s2_rgb     <= r_s1_blank_n ? w_pix : 24'd0;
      r_s2_hs      <= r_s1_hs;
      r_s2_vs      <= r_s1_vs;
      r_s2_blank_n <= r_s1_blank_n;
      r_s2_vga_clk <= r_s1_vga_clk;
    end
  end

  assign readdata              = r_readdata;
  assign {VGA_R, VGA_G, VGA_B} = r_s2_rgb;
  assign VGA_HS                = r_s2_hs;
  assign VGA_VS                = r_s2_vs;
  assign VGA_BLANK_n           = r_s2_blank_n;
  assign VGA_CLK               = r_s2_vga_clk;
  assign VGA_SYNC_n            = 1'b0;

  assign w_unused = &{1'b0, writedata, w_hcount[0]};

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised successor to the single-ball VGA display block: draws N_BALLS independently programmable filled circles over a background colour on the 640x480 VGA output.
- Sits on the Avalon-MM slave bus with the accelerator registers.
- Register writes land in staging registers. They take effect only on a commit that is applied at the start of vertical blank, so the image never tears.
- Adds registered readback (status and frame counter) and a pipelined pixel path with aligned sync.

Parameters:
- N_BALLS, 4, number of circles; 1..8.
- RAD_W, 6, radius width in pixels.
- ADDR_W, 4, bus address width; must be >= clog2(2*N_BALLS+2).

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high
- chipselect  in  1  slave select
- write  in  1  write strobe
- read  in  1  read strobe
- address  in  ADDR_W  word address
- writedata  in  32  write data
- readdata  out  32  read data, latency 1
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1 each  VGA control

Behaviour:
- Reset and clock: one clock (clk); reset is asynchronous and active-high.
- Register map, word addresses:
  - 2i, POS_i: [25:16] pos_v, [9:0] pos_h, in pixels.
  - 2i+1, ATTR_i: [31] enable, [24+RAD_W-1:24] radius, [23:0] RGB.
  - 2N, BG: [23:0] background RGB.
  - 2N+1, CTRL: write bit0=1 sets pending. Read returns {pending[31], 15'b0, frame_count[15:0]}.
  - Unmapped writes are ignored; unmapped reads return 0.
- Staging vs active:
  - Each POS/ATTR/BG register has a staging copy (bus-written) and an active copy (used for drawing).
  - Readback of POS/ATTR/BG returns the staging copy.
- Commit boundary: the cycle with hcount==1599 and vcount==479 (last clock of the last active line).
  - On that cycle, frame_count increments (wraps 0xFFFF to 0).
  - If pending==1, all staging copies are copied to active and pending clears.
- Simultaneous events on the boundary cycle:
  - The copy uses the staging value before any write in that same cycle.
  - A CTRL commit written on that cycle is not consumed: pending ends at 1 and applies at the next boundary.
- readdata is registered and valid the cycle after chipselect&&read. It holds its value otherwise.
- Timing: 640x480 at 25 MHz pixel rate, identical timing constants to the existing counters. Pixel column x = hcount[10:1], row y = vcount.
- Hit test per ball:
  - dx = |x - pos_h| and dy = |y - pos_v|, 10 bits unsigned.
  - Squares are 20 bits; sum is 21 bits; compare against radius^2 at 2*RAD_W bits, zero-extended.
  - hit = enable && (dx^2 + dy^2 < r^2), strictly less than.
  - Radius 0 never hits.
- Pixel pipeline:
  - Stage 1 registers the per-ball hit vector and colours.
  - Stage 2 registers the final RGB: the lowest-index hitting ball wins, else background, and 0 when blanked.
  - VGA_HS, VGA_VS, VGA_BLANK_n and VGA_CLK are delayed 2 clk cycles so they stay aligned with RGB.
- VGA_SYNC_n is held at 0.
- Reset values:
  - RGB = 0, HS = VS = 1, BLANK_n = 0, VGA_CLK = 0, readdata = 0.
  - All enables 0 (staging and active), positions and radii 0, background = 0x000080 (staging and active).
  - pending = 0, frame_count = 0, counters = 0.
- Reset asserted mid-frame returns everything to reset values immediately; no commit survives.

Decomposition:
- Package vga_pkg:
  - H/V timing constants (HACTIVE 1280, HFRONT_PORCH 32, HSYNC 192, HBACK_PORCH 96, VACTIVE 480, VFRONT_PORCH 10, VSYNC 2, VBACK_PORCH 33).
  - ball_t struct: pos_h, pos_v, radius, rgb, enable.
  - Register offset functions of N_BALLS.
- Sub-modules:
  - Reuse vga_counters unchanged.
  - One new sub-module, ball_hit_unit: combinational distance compare, instantiated N_BALLS times.
- Top module scope: bus decode, staging/active banks, commit FSM and pipeline.

Test Plan:
- After reset, no writes → every active pixel is 0x000080; readdata 0; the CTRL read after the 1st boundary shows frame_count=1, pending=0.
- Program ball 0 with POS=(v50,h100), ATTR={en,r=16,0xFF0000}, then CTRL=1 → pixels unchanged until the boundary; next frame (100,50)=FF0000, (115,50)=FF0000, (116,50)=000080; RGB lags hcount by 2 cycles, aligned with BLANK_n.
- Program ball 1 at the same centre with r=20 and colour 00FF00, then commit → (100,50)=FF0000 (ball 0 wins); (118,50)=00FF00.
- Write CTRL=1 exactly on the boundary cycle → no copy that frame; pending reads 1; copy happens at the next boundary.
- Write POS_0 without a commit → readback shows the new value; the display is unchanged across 3 frames.
- Assert reset mid-line with ball 0 enabled → RGB=0, HS=VS=1, ball disabled, frame_count=0 after release.
